weight_mem_arbiter: RTL and testbench

- Shares the single-port weight SRAM among N_REQ engines: 0 = UART weight loader, 1 = forward-prop, 2 = back-prop.
- Grants one owner at a time and supports locked bursts.
- Forwards the owner's access to the SRAM and routes read data back to the requester that issued the read.
- Sits between the neural-network engines and the weight memory macro.

---
 rtl/weight_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_weight_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_mem_arbiter.sv
// -----------------------------------------------------------------------------
// weight_mem_arbiter
//
// Shares one single-port weight SRAM among N_REQ engines (0 = UART weight
// loader, 1 = forward-prop, 2 = back-prop). One engine owns the SRAM at a time.
// The owner may hold it across a locked burst. Its accesses go straight to the
// macro. Read data comes back to whichever engine issued the read, even when
// ownership has moved on by the time the data arrives.
//
// Optional build macro:
//   WMA_FIXED_PRIO_EN - when defined, the lowest-index requester always wins
//                       arbitration. When undefined (default), arbitration is
//                       round-robin, starting after the last owner.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req[N]       per-requester access request
//   lock[N]      per-requester burst (hold ownership) flag
//   we[N]        per-requester write enable
//   addr, wdata  packed per-requester address / write data
//   gnt[N]       one-hot, access of requester i accepted this cycle
//   rvalid[N]    one-hot, read data for requester i valid this cycle
//   rdata        shared read data bus (zero when no rvalid)
//   mem_*        SRAM macro interface (mem_rdata arrives RD_LAT after a read)
//   busy         ownership held or reads still in flight
// -----------------------------------------------------------------------------
module weight_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int N_REQ     = 3,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic {ARB, OWN} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   w_ownerNext;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cntNext;
  logic [CW-1:0]   w_cntInc;
`ifndef WMA_FIXED_PRIO_EN
  logic [OW-1:0]   r_last;
  logic [OW-1:0]   w_lastNext;
  logic [OW-1:0]   w_cand;
`endif

  logic [OW-1:0]   w_winner;
  logic            w_found;
  logic            w_granted;
  logic            w_others;
  logic            w_forced;
  logic [N_REQ-1:0] w_ownerOh;

  logic [RD_LAT-1:0] r_pipeValid;
  logic [OW-1:0]     r_pipeId [RD_LAT];

  // The current owner as a one-hot mask, used for the grant and to spot any
  // competing requests during a burst.
  always_comb begin
    w_ownerOh = N_REQ'(1) << r_owner;
    w_granted = (r_state == OWN) && req[r_owner];
    w_others  = |(req & ~w_ownerOh);
  end

  // Pick the arbitration winner. Round-robin rotates the search start to just
  // after the previous owner, so a requester that keeps asking cannot starve
  // the others. The fixed-priority build simply takes the lowest index.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
`ifdef WMA_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[i]) begin
        w_found  = 1'b1;
        w_winner = OW'(i);
      end
    end
`else
    w_cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = OW'((int'(r_last) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
`endif
  end

  // Next-state logic. A granted access bumps the burst count, which saturates.
  // The forced release compares against the count after this access. That way
  // a locked owner gets exactly MAX_BURST beats before a waiting requester
  // takes over. Dropping lock releases the SRAM whether or not this cycle
  // carried an access.
  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_cntNext   = r_cnt;
    w_cntInc    = r_cnt;
    w_forced    = 1'b0;
`ifndef WMA_FIXED_PRIO_EN
    w_lastNext  = r_last;
`endif
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_stateNext = OWN;
          w_ownerNext = w_winner;
          w_cntNext   = '0;
        end
      end
      OWN: begin
        if (w_granted && (r_cnt != BURST_MAX)) begin
          w_cntInc = r_cnt + CW'(1);
        end
        w_forced = (w_cntInc == BURST_MAX) && w_others;
        if (!lock[r_owner] || w_forced) begin
          w_stateNext = ARB;
          w_cntNext   = '0;
`ifndef WMA_FIXED_PRIO_EN
          w_lastNext  = r_owner;
`endif
        end else begin
          w_cntNext = w_cntInc;
        end
      end
      default: begin
        w_stateNext = ARB;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
      r_owner <= '0;
      r_cnt   <= '0;
`ifndef WMA_FIXED_PRIO_EN
      r_last  <= OW'(N_REQ - 1);
`endif
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
      r_cnt   <= w_cntNext;
`ifndef WMA_FIXED_PRIO_EN
      r_last  <= w_lastNext;
`endif
    end
  end

  // Read-return pipe. It tags each granted read with the requester that issued
  // it, so the data reaches that requester even after ownership has changed.
  // Reset empties the pipe, so reads in flight at reset never produce rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipeValid[i] <= 1'b0;
        r_pipeId[i]    <= '0;
      end
    end else begin
      r_pipeValid[0] <= w_granted & ~we[r_owner];
      r_pipeId[0]    <= r_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeId[i]    <= r_pipeId[i-1];
      end
    end
  end

  // Output drive. The owner's slice goes to the SRAM only while it owns it.
  // Otherwise every SRAM output stays at zero.
  always_comb begin
    gnt       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rvalid    = '0;
    rdata     = '0;
    if (r_state == OWN) begin
      gnt       = w_granted ? w_ownerOh : '0;
      mem_en    = w_granted;
      mem_we    = we[r_owner];
      mem_addr  = addr[r_owner*ADDR_W +: ADDR_W];
      mem_wdata = wdata[r_owner*DATA_W +: DATA_W];
    end
    if (r_pipeValid[RD_LAT-1]) begin
      rvalid = N_REQ'(1) << r_pipeId[RD_LAT-1];
      rdata  = mem_rdata;
    end
    busy = (r_state == OWN) || (|r_pipeValid);
  end

endmodule

// File: tb/tb_weight_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_weight_mem_arbiter
//
// Directed testbench for weight_mem_arbiter with default parameters
// (3 requesters, RD_LAT = 2, MAX_BURST = 16). It contains a small SRAM model
// that answers reads RD_LAT cycles later from a fixed address/data map and
// drives 16'hDEAD when no read is returning. Inputs are driven 1 time unit
// after each rising edge, and outputs are checked 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_weight_mem_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int N_REQ     = 3;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 16;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    busy;

  int checks = 0;
  int fails  = 0;

  weight_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ),
    .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: fixed contents, so the expected read data is known up front.
  function automatic logic [DATA_W-1:0] memValue(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0040: memValue = 16'hBEEF;
      16'h0010: memValue = 16'h1234;
      default:  memValue = 16'hA000 ^ a;
    endcase
  endfunction

  logic [DATA_W-1:0] rdPipe [RD_LAT];

  always @(posedge clk) begin
    rdPipe[0] <= (mem_en && !mem_we) ? memValue(mem_addr) : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign mem_rdata = rdPipe[RD_LAT-1];

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    req   = '0;
    lock  = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Outputs must all be zero while reset is held, even with busy-looking inputs.
  task automatic test_reset();
    rst   = 1'b1;
    req   = 3'b111;
    lock  = 3'b111;
    we    = 3'b101;
    addr  = 48'h1111_2222_3333;
    wdata = 48'h4444_5555_6666;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      #1;
      checks++;
      if (gnt !== 3'b000 || rvalid !== 3'b000 || rdata !== 16'h0) begin
        fails++;
        $display("[TB] FAIL reset_gnt_rvalid: got gnt=%b rvalid=%b rdata=%h want 000 000 0000", gnt, rvalid, rdata);
      end
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_mem: got en=%b we=%b addr=%h wd=%h busy=%b want all 0", mem_en, mem_we, mem_addr, mem_wdata, busy);
      end
    end
    doReset();
  endtask

  // A single read by requester 1: grant one cycle later, data RD_LAT after the grant.
  task automatic test_single_read();
    doReset();
    nextCycle();
    req = 3'b010;
    addr[31:16] = 16'h0040;
    #1;
    checks++;
    if (gnt !== 3'b000) begin fails++; $display("[TB] FAIL t1_c0_gnt: got %b want 000", gnt); end
    nextCycle();
    #1;
    checks++;
    if (gnt !== 3'b010) begin fails++; $display("[TB] FAIL t1_c1_gnt: got %b want 010", gnt); end
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040) begin
      fails++;
      $display("[TB] FAIL t1_c1_mem: got en=%b we=%b addr=%h want 1 0 0040", mem_en, mem_we, mem_addr);
    end
    nextCycle();
    req = 3'b000;
    #1;
    checks++;
    if (gnt !== 3'b000 || mem_en !== 1'b0 || rvalid !== 3'b000 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL t1_c2: got gnt=%b en=%b rvalid=%b busy=%b want 000 0 000 1", gnt, mem_en, rvalid, busy);
    end
    nextCycle();
    #1;
    checks++;
    if (rvalid !== 3'b010 || rdata !== 16'hBEEF) begin
      fails++;
      $display("[TB] FAIL t1_c3_read: got rvalid=%b rdata=%h want 010 beef", rvalid, rdata);
    end
    nextCycle();
    #1;
    checks++;
    if (rvalid !== 3'b000 || rdata !== 16'h0000 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL t1_c4_idle: got rvalid=%b rdata=%h busy=%b want 000 0000 0", rvalid, rdata, busy);
    end
  endtask

  // All three request continuously without lock: 0,1,2,0 with a bubble between each.
  task automatic test_round_robin();
    logic [2:0] expGnt [8];
    logic [2:0] expRv  [8];
    expGnt = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    expRv  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    doReset();
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      req = 3'b111;
      #1;
      checks++;
      if (gnt !== expGnt[c]) begin
        fails++;
        $display("[TB] FAIL t2_gnt_c%0d: got %b want %b", c, gnt, expGnt[c]);
      end
      checks++;
      if (rvalid !== expRv[c]) begin
        fails++;
        $display("[TB] FAIL t2_rvalid_c%0d: got %b want %b", c, rvalid, expRv[c]);
      end
    end
    nextCycle();
    clearInputs();
  endtask

  // Requester 2 holds a 5-beat locked write burst while requester 1 waits.
  task automatic test_locked_burst();
    doReset();
    nextCycle();
    req  = 3'b100;
    lock = 3'b100;
    we   = 3'b100;
    addr = {16'h0000, 16'h0010, 16'h0000};
    #1;
    checks++;
    if (gnt !== 3'b000) begin fails++; $display("[TB] FAIL t3_c0_gnt: got %b want 000", gnt); end
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      req = 3'b110;
      lock = (i < 4) ? 3'b100 : 3'b000;
      addr[47:32]  = 16'(i);
      wdata[47:32] = 16'h5000 + 16'(i);
      #1;
      checks++;
      if (gnt !== 3'b100) begin fails++; $display("[TB] FAIL t3_beat%0d_gnt: got %b want 100", i, gnt); end
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 16'(i) || mem_wdata !== 16'h5000 + 16'(i)) begin
        fails++;
        $display("[TB] FAIL t3_beat%0d_mem: got we=%b addr=%h wd=%h want 1 %h %h", i, mem_we, mem_addr, mem_wdata, 16'(i), 16'h5000 + 16'(i));
      end
    end
    nextCycle();
    req = 3'b010;
    lock = 3'b000;
    we = 3'b000;
    #1;
    checks++;
    if (gnt !== 3'b000) begin fails++; $display("[TB] FAIL t3_bubble_gnt: got %b want 000", gnt); end
    nextCycle();
    #1;
    checks++;
    if (gnt !== 3'b010 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
      fails++;
      $display("[TB] FAIL t3_req1_gnt: got gnt=%b addr=%h we=%b want 010 0010 0", gnt, mem_addr, mem_we);
    end
    nextCycle();
    req = 3'b000;
    #1;
    nextCycle();
    #1;
    checks++;
    if (rvalid !== 3'b010 || rdata !== 16'h1234) begin
      fails++;
      $display("[TB] FAIL t3_read: got rvalid=%b rdata=%h want 010 1234", rvalid, rdata);
    end
  endtask

  // Requester 0 wants 20 locked beats while requester 1 waits. The burst is
  // cut after beat 16, requester 1 gets one access, then requester 0 resumes.
  task automatic test_forced_release();
    int beats0;
    bit got1;
    logic [2:0] exp;
    beats0 = 0;
    got1   = 1'b0;
    doReset();
    for (int c = 0; c < 25; c++) begin
      nextCycle();
      req[0]      = (beats0 < 20);
      lock[0]     = (beats0 < 19);
      we[0]       = 1'b1;
      addr[15:0]  = 16'(beats0);
      req[1]      = !got1;
      lock[1]     = 1'b0;
      we[1]       = 1'b0;
      req[2]      = 1'b0;
      if (c >= 1 && c <= 16)       exp = 3'b001;
      else if (c == 18)            exp = 3'b010;
      else if (c >= 20 && c <= 23) exp = 3'b001;
      else                         exp = 3'b000;
      #1;
      checks++;
      if (gnt !== exp) begin
        fails++;
        $display("[TB] FAIL t4_gnt_c%0d: got %b want %b", c, gnt, exp);
      end
      if (gnt[0]) beats0++;
      if (gnt[1]) got1 = 1'b1;
    end
    checks++;
    if (beats0 != 20) begin fails++; $display("[TB] FAIL t4_beats: got %0d want 20", beats0); end
    clearInputs();
  endtask

  // Requester 1 reads and releases, and requester 2 takes over. The earlier read
  // must still return to requester 1.
  task automatic test_read_after_handoff();
    doReset();
    nextCycle();
    req = 3'b110;
    addr = {16'h0020, 16'h0010, 16'h0000};
    #1;
    nextCycle();
    #1;
    checks++;
    if (gnt !== 3'b010 || mem_addr !== 16'h0010) begin
      fails++;
      $display("[TB] FAIL t5_c1: got gnt=%b addr=%h want 010 0010", gnt, mem_addr);
    end
    nextCycle();
    req = 3'b100;
    #1;
    checks++;
    if (gnt !== 3'b000) begin fails++; $display("[TB] FAIL t5_c2_gnt: got %b want 000", gnt); end
    nextCycle();
    #1;
    checks++;
    if (gnt !== 3'b100 || rvalid !== 3'b010 || rdata !== 16'h1234) begin
      fails++;
      $display("[TB] FAIL t5_c3: got gnt=%b rvalid=%b rdata=%h want 100 010 1234", gnt, rvalid, rdata);
    end
    nextCycle();
    req = 3'b000;
    #1;
    checks++;
    if (rvalid !== 3'b000) begin fails++; $display("[TB] FAIL t5_c4_rvalid: got %b want 000", rvalid); end
    nextCycle();
    #1;
    checks++;
    if (rvalid !== 3'b100 || rdata !== 16'hA020) begin
      fails++;
      $display("[TB] FAIL t5_c5: got rvalid=%b rdata=%h want 100 a020", rvalid, rdata);
    end
  endtask

  // Reset hits while a read is in flight. The read must never return.
  // Afterwards, requests from 1 and 2 together go to requester 1 in both builds.
  task automatic test_reset_during_read();
    doReset();
    nextCycle();
    req = 3'b001;
    addr[15:0] = 16'h0040;
    #1;
    nextCycle();
    #1;
    checks++;
    if (gnt !== 3'b001) begin fails++; $display("[TB] FAIL t6_c1_gnt: got %b want 001", gnt); end
    nextCycle();
    req = 3'b000;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b000 || rvalid !== 3'b000 || rdata !== 16'h0 || mem_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL t6_in_reset: got gnt=%b rvalid=%b rdata=%h en=%b busy=%b want all 0", gnt, rvalid, rdata, mem_en, busy);
    end
    nextCycle();
    rst = 1'b0;
    #1;
    checks++;
    if (rvalid !== 3'b000 || rdata !== 16'h0) begin
      fails++;
      $display("[TB] FAIL t6_dropped_read: got rvalid=%b rdata=%h want 000 0000", rvalid, rdata);
    end
    nextCycle();
    req = 3'b110;
    #1;
    checks++;
    if (rvalid !== 3'b000 || gnt !== 3'b000 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL t6_after: got rvalid=%b gnt=%b busy=%b want 000 000 0", rvalid, gnt, busy);
    end
    nextCycle();
    #1;
    checks++;
    if (gnt !== 3'b010) begin fails++; $display("[TB] FAIL t6_prio_gnt: got %b want 010", gnt); end
    nextCycle();
    clearInputs();
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    $display("[TB] starting weight_mem_arbiter tests");
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_burst();
    test_forced_release();
    test_read_after_handoff();
    test_reset_during_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
